// File: rtl/demux_32_bit_1_2_buf_pkg.sv
// Shared constants for the 1:2 buffered demux: select encodings, default geometry, counter width.
// No logic; imported by the top and by the FIFO sub-module.
package demux_32_bit_1_2_buf_pkg;

    localparam logic SEL_OUT0   = 1'b0;
    localparam logic SEL_OUT1   = 1'b1;

    localparam int   DEF_WIDTH  = 32;
    localparam int   DEF_DEPTH  = 4;
    localparam int   CNT_W      = 16;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

endpackage

// File: rtl/demux_32_bit_1_2_buf_sync_fifo.sv
// sync_fifo_32: registered FIFO, a push at edge N is the head after edge N (no bypass).
// Push is ignored when full, pop is ignored when empty; head reads zero while empty.
module sync_fifo_32
    import demux_32_bit_1_2_buf_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB tells a full ring apart from an empty one.
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data;
            wr_ptr_d                = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/demux_32_bit_1_2_buf.sv
// Registered 1:2 demux into two FIFOs; accepted word visible on its output one cycle later.
// in_ready = !full of the selected FIFO only; per-output pop counters built under DEMUX_STATS_EN.
module demux_32_bit_1_2_buf
    import demux_32_bit_1_2_buf_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    logic full0, full1;
    logic empty0, empty1;
    logic push0, push1;

    // Ready looks only at the addressed FIFO, so a full FIFO never blocks the other.
    assign in_ready   = (in_sel == SEL_OUT1) ? !full1 : !full0;
    assign push0      = in_valid && in_ready && (in_sel == SEL_OUT0);
    assign push1      = in_valid && in_ready && (in_sel == SEL_OUT1);
    assign out0_valid = !empty0;
    assign out1_valid = !empty1;

    sync_fifo_32 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push0),
        .push_data (in_data),
        .pop       (out0_ready),
        .full      (full0),
        .empty     (empty0),
        .head      (out0_data)
    );

    sync_fifo_32 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push1),
        .push_data (in_data),
        .pop       (out1_ready),
        .full      (full1),
        .empty     (empty1),
        .head      (out1_data)
    );

`ifdef DEMUX_STATS_EN
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (out0_valid && out0_ready) cnt0_d = cnt0_q + CNT_ONE;
        if (out1_valid && out1_ready) cnt1_d = cnt1_q + CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;
`else
    assign cnt0 = '0;
    assign cnt1 = '0;
`endif

endmodule
